// File: rtl/afe_pkg.sv
// Shared constants for the AFE capture path: FSM state encodings and counter widths.
package afe_pkg;

    localparam int unsigned AFE_FRAME_CNT_W = 16;
    localparam int unsigned AFE_STATE_W     = 3;

    localparam logic [AFE_STATE_W-1:0] ST_IDLE      = 3'd0;
    localparam logic [AFE_STATE_W-1:0] ST_WAIT_SYNC = 3'd1;
    localparam logic [AFE_STATE_W-1:0] ST_DELAY     = 3'd2;
    localparam logic [AFE_STATE_W-1:0] ST_CAPTURE   = 3'd3;
    localparam logic [AFE_STATE_W-1:0] ST_HALT      = 3'd4;

endpackage

// File: rtl/afe_capture_fifo.sv
// Fall-through FIFO for captured samples; synchronous flush overrides push and pop.
module afe_capture_fifo #(
    parameter int unsigned WIDTH = 17,
    parameter int unsigned DEPTH = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             empty,
    output logic             full
);

    localparam int unsigned AW      = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push;
    logic             do_pop;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);

    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
            if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_data;
    end

    // Zero while empty so the stream reads clean after reset and flush.
    assign head = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/afe_frame_capture.sv
// Sync-aligned AFE frame capture: waits for sync plus a fixed delay, then streams framed samples via a FIFO.
module afe_frame_capture
    import afe_pkg::*;
#(
    parameter int unsigned DATA_W       = 16,
    parameter int unsigned FRAME_LEN    = 1024,
    parameter int unsigned FIFO_DEPTH   = 16,
    parameter int unsigned SYNC_LATENCY = 4
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       arm,
    input  logic                       sync_in,
    input  logic [DATA_W-1:0]          adc_data,
    input  logic                       adc_valid,
    output logic [DATA_W-1:0]          out_data,
    output logic                       out_valid,
    output logic                       out_last,
    input  logic                       out_ready,
    output logic                       capturing,
    output logic                       overflow,
    output logic [AFE_FRAME_CNT_W-1:0] frame_count
);

    localparam logic [15:0] LAST_IDX   = 16'(FRAME_LEN - 1);
    localparam logic [7:0]  DELAY_LOAD = (SYNC_LATENCY == 0) ? 8'd0 : 8'(SYNC_LATENCY - 1);

    logic [AFE_STATE_W-1:0]     state_q, state_d;
    logic [7:0]                 delay_q, delay_d;
    logic [15:0]                index_q, index_d;
    logic [AFE_FRAME_CNT_W-1:0] frame_count_q, frame_count_d;
    logic                       overflow_q, overflow_d;
    logic                       capturing_q, capturing_d;

    logic                       fifo_flush;
    logic                       fifo_push;
    logic                       fifo_pop;
    logic                       fifo_full;
    logic                       fifo_empty;
    logic [DATA_W:0]            fifo_head;
    logic                       sample_last;

    assign sample_last = (index_q == LAST_IDX);

    always_comb begin
        state_d       = state_q;
        delay_d       = delay_q;
        index_d       = index_q;
        frame_count_d = frame_count_q;
        overflow_d    = overflow_q;
        capturing_d   = (state_q == ST_CAPTURE);
        fifo_flush    = 1'b0;
        fifo_push     = 1'b0;
        // Dropping arm wins over every other event, including a same-cycle push or sync.
        if (!arm) begin
            state_d       = ST_IDLE;
            delay_d       = '0;
            index_d       = '0;
            frame_count_d = '0;
            overflow_d    = 1'b0;
            fifo_flush    = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: state_d = ST_WAIT_SYNC;
                ST_WAIT_SYNC: begin
                    if (sync_in) begin
                        if (SYNC_LATENCY == 0) begin
                            state_d = ST_CAPTURE;
                        end else begin
                            state_d = ST_DELAY;
                            delay_d = DELAY_LOAD;
                        end
                    end
                end
                ST_DELAY: begin
                    if (delay_q == '0) state_d = ST_CAPTURE;
                    else               delay_d = delay_q - 8'd1;
                end
                ST_CAPTURE: begin
                    // Full is the pre-pop level, so a push against a full FIFO drops even if a pop coincides.
                    if (adc_valid) begin
                        if (fifo_full) begin
                            overflow_d = 1'b1;
                            state_d    = ST_HALT;
                        end else begin
                            fifo_push = 1'b1;
                            if (sample_last) begin
                                index_d       = '0;
                                frame_count_d = frame_count_q + 16'd1;
                            end else begin
                                index_d = index_q + 16'd1;
                            end
                        end
                    end
                end
                ST_HALT: state_d = ST_HALT;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_IDLE;
            delay_q       <= '0;
            index_q       <= '0;
            frame_count_q <= '0;
            overflow_q    <= 1'b0;
            capturing_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            delay_q       <= delay_d;
            index_q       <= index_d;
            frame_count_q <= frame_count_d;
            overflow_q    <= overflow_d;
            capturing_q   <= capturing_d;
        end
    end

    assign fifo_pop = out_valid && out_ready;

    afe_capture_fifo #(
        .WIDTH (DATA_W + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .flush     (fifo_flush),
        .push      (fifo_push),
        .push_data ({sample_last, adc_data}),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    assign out_valid   = !fifo_empty;
    assign out_data    = fifo_head[DATA_W-1:0];
    assign out_last    = fifo_head[DATA_W];
    assign capturing   = capturing_q;
    assign overflow    = overflow_q;
    assign frame_count = frame_count_q;

endmodule
